// File: rtl/refill_arbiter.sv
// refill_arbiter
//   Shares one external memory transaction port between N_REQ cache
//   requesters. An idle port grants by round-robin, or by lowest index when
//   FIXED_PRIO=1. The winner's write/addr/len are latched and presented
//   downstream. The owner keeps the port until its final data beat, then gets
//   a one-cycle completion pulse. Beat-count mismatches are flagged.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   req_valid/write   per-requester request and direction (1 = write-back)
//   req_addr/len      packed per-requester start address / burst length
//   req_ready         one-cycle accept pulse to the owner (handshake cycle)
//   req_done          one-cycle completion pulse to the owner
//   bus_valid/ready   downstream transaction handshake
//   bus_write/addr/len/id  latched transaction fields and owner index
//   bus_beat/last     downstream data beat and final-beat qualifier
//   busy              port is owned or finishing
//   protocol_err      one-cycle pulse on a beat-count mismatch
module refill_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0]                req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0]     req_addr,
  input  logic [N_REQ*LEN_WIDTH-1:0]      req_len,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                req_done,
  output logic                            bus_valid,
  input  logic                            bus_ready,
  output logic                            bus_write,
  output logic [ADDR_WIDTH-1:0]           bus_addr,
  output logic [LEN_WIDTH-1:0]            bus_len,
  output logic [1:0]                      bus_id,
  input  logic                            bus_beat,
  input  logic                            bus_last,
  output logic                            busy,
  output logic                            protocol_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            last_grant;
  logic [LEN_WIDTH-1:0]  beat_cnt;

  logic                  any_req;
  logic                  found;
  logic [1:0]            winner;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic                  handshake;
  logic                  at_len;

  // Winner selection. Round-robin scans upward starting one past the last
  // owner so the previous owner is considered last.
  always_comb begin
    any_req = |req_valid;
    found   = 1'b0;
    winner  = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) winner = 2'(i);
      end
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!found && req_valid[i] && (i == (int'(last_grant) + k) % N_REQ)) begin
            winner = 2'(i);
            found  = 1'b1;
          end
        end
      end
    end

    sel_write = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == 2'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign handshake = bus_valid && bus_ready;
  assign busy      = (state != IDLE);

  // beat_cnt counts beats already seen, so the final beat must arrive while
  // beat_cnt equals bus_len.
  assign at_len       = (beat_cnt == bus_len);
  assign protocol_err = (state == BUSY) && bus_beat && (bus_last ? !at_len : at_len);

  // Accept pulse is combinational so the owner sees it in the handshake cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = handshake && (bus_id == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus_valid  <= 1'b0;
      req_done   <= '0;
      bus_write  <= 1'b0;
      bus_addr   <= '0;
      bus_len    <= '0;
      bus_id     <= '0;
      last_grant <= 2'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bus_write <= sel_write;
            bus_addr  <= sel_addr;
            bus_len   <= sel_len;
            bus_id    <= winner;
            bus_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_beat) begin
            if (beat_cnt != {LEN_WIDTH{1'b1}}) beat_cnt <= beat_cnt + 1'b1;
            if (bus_last) begin
              for (int i = 0; i < N_REQ; i++) begin
                req_done[i] <= (bus_id == 2'(i));
              end
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (FIXED_PRIO == 0) last_grant <= bus_id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_refill_arbiter.sv
// Testbench for refill_arbiter: a round-robin and a fixed-priority instance
// share one stimulus. Each is tracked by a transaction-level model and
// compared every cycle, with directed literal expectations on top.
module tb_refill_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    rv, rw;
  logic [N*AW-1:0] ra;
  logic [N*LW-1:0] rl;
  logic            br, bb, bl;

  logic [N-1:0] rr_ready, rr_done, fp_ready, fp_done;
  logic         rr_valid, rr_write, rr_busy, rr_err;
  logic         fp_valid, fp_write, fp_busy, fp_err;
  logic [AW-1:0] rr_addr, fp_addr;
  logic [LW-1:0] rr_len, fp_len;
  logic [1:0]    rr_id, fp_id;

  refill_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(rv), .req_write(rw), .req_addr(ra), .req_len(rl),
    .req_ready(rr_ready), .req_done(rr_done), .bus_valid(rr_valid), .bus_ready(br),
    .bus_write(rr_write), .bus_addr(rr_addr), .bus_len(rr_len), .bus_id(rr_id),
    .bus_beat(bb), .bus_last(bl), .busy(rr_busy), .protocol_err(rr_err));

  refill_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(rv), .req_write(rw), .req_addr(ra), .req_len(rl),
    .req_ready(fp_ready), .req_done(fp_done), .bus_valid(fp_valid), .bus_ready(br),
    .bus_write(fp_write), .bus_addr(fp_addr), .bus_len(fp_len), .bus_id(fp_id),
    .bus_beat(bb), .bus_last(bl), .busy(fp_busy), .protocol_err(fp_err));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, whether the downstream side
  // accepted it, whether the final beat has been seen, and beats so far.
  typedef struct {
    int            owner;
    bit            accepted;
    bit            finishing;
    int            beats;
    int            last_grant;
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } mdl_t;

  mdl_t m_rr, m_fp;
  int   q_mrr[$], q_mfp[$];
  bit   cmp_en = 1'b0;
  int   cyc = 0;

  function automatic mdl_t mstep(input mdl_t m, input bit fixed);
    mdl_t n;
    int   w;
    n = m;
    w = -1;
    if (rst) begin
      n.owner = -1; n.accepted = 0; n.finishing = 0; n.beats = 0;
      n.last_grant = N - 1; n.id = 0; n.wr = 1'b0; n.addr = '0; n.len = '0;
    end else if (m.owner < 0) begin
      if (fixed) begin
        for (int i = N - 1; i >= 0; i--) if (rv[i]) w = i;
      end else begin
        for (int k = 1; k <= N; k++)
          if (w < 0 && rv[(m.last_grant + k) % N]) w = (m.last_grant + k) % N;
      end
      if (w >= 0) begin
        n.owner = w; n.accepted = 0; n.finishing = 0; n.id = w;
        n.wr = rw[w]; n.addr = ra[w*AW +: AW]; n.len = rl[w*LW +: LW];
      end
    end else if (!m.accepted) begin
      if (br) begin n.accepted = 1; n.beats = 0; end
    end else if (!m.finishing) begin
      if (bb) begin
        if (bl) n.finishing = 1;
        if (m.beats < (1 << LW) - 1) n.beats = m.beats + 1;
      end
    end else begin
      if (!fixed) n.last_grant = m.owner;
      n.owner = -1; n.accepted = 0; n.finishing = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst && m_rr.owner >= 0 && !m_rr.accepted && br) q_mrr.push_back(m_rr.owner);
    if (!rst && m_fp.owner >= 0 && !m_fp.accepted && br) q_mfp.push_back(m_fp.owner);
    m_rr <= mstep(m_rr, 1'b0);
    m_fp <= mstep(m_fp, 1'b1);
    if (rst) cmp_en <= 1'b1;
    cyc <= cyc + 1;
  end

  task automatic cmp(input string t, input mdl_t m,
                     input logic [N-1:0] rdy, input logic [N-1:0] dn,
                     input logic vld, input logic wr, input logic [AW-1:0] ad,
                     input logic [LW-1:0] ln, input logic [1:0] id,
                     input logic bsy, input logic er);
    logic [N-1:0] e_rdy, e_done;
    logic         e_vld, e_busy, e_err;
    e_vld  = (m.owner >= 0) && !m.accepted;
    e_busy = (m.owner >= 0);
    e_rdy  = '0;
    if (e_vld && br) e_rdy[m.owner] = 1'b1;
    e_done = '0;
    if (m.owner >= 0 && m.finishing) e_done[m.owner] = 1'b1;
    e_err = (m.owner >= 0) && m.accepted && !m.finishing && bb &&
            (bl ? (m.beats != int'(m.len)) : (m.beats == int'(m.len)));
    chk({t, ".bus_valid"}, vld, e_vld);
    chk({t, ".busy"}, bsy, e_busy);
    chk({t, ".req_ready"}, rdy, e_rdy);
    chk({t, ".req_done"}, dn, e_done);
    chk({t, ".protocol_err"}, er, e_err);
    chk({t, ".bus_id"}, id, m.id);
    chk({t, ".bus_addr"}, ad, m.addr);
    chk({t, ".bus_len"}, ln, m.len);
    chk({t, ".bus_write"}, wr, m.wr);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("rr", m_rr, rr_ready, rr_done, rr_valid, rr_write, rr_addr, rr_len, rr_id, rr_busy, rr_err);
      cmp("fp", m_fp, fp_ready, fp_done, fp_valid, fp_write, fp_addr, fp_len, fp_id, fp_busy, fp_err);
    end
  end

  // Observed-event log from the DUTs, used for sequence-level expectations.
  int   rr_ready_cnt = 0, rr_done_cnt = 0, rr_err_cnt = 0;
  int   rr_ids[$], fp_ids[$];
  int   last_done = -1;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (rr_ready != '0) begin
        rr_ready_cnt <= rr_ready_cnt + 1;
        rr_ids.push_back(int'(rr_id));
      end
      if (fp_ready != '0) fp_ids.push_back(int'(fp_id));
      if (rr_done != '0) begin
        rr_done_cnt <= rr_done_cnt + 1;
        last_done   <= cyc;
      end
      if (rr_err) rr_err_cnt <= rr_err_cnt + 1;
      if (rr_valid && !prev_valid && last_done >= 0)
        chk("turnaround_ge2", 64'((cyc - last_done) >= 2), 64'd1);
      prev_valid <= rr_valid;
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rr_valid) break;
    end
    if (!rr_valid) chk("wait_valid.timeout", rr_valid, 1);
  endtask

  task automatic beat(input logic last, input logic [N-1:0] keep, output logic err);
    @(posedge clk); #1;
    rv = rv & keep;
    bb = 1'b1;
    bl = last;
    @(negedge clk);
    err = rr_err;
  endtask

  task automatic end_beats();
    @(posedge clk); #1;
    bb = 1'b0;
    bl = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int   n, rb, eb, db, ib_rr, ib_fp, mb_rr, mb_fp;
    logic e1, e2, e3;
    int   exp_rr[5];
    int   exp_fp[5];
    exp_rr = '{0, 1, 0, 1, 1};
    exp_fp = '{0, 0, 0, 0, 1};

    rst = 1'b1; rv = '0; rw = '0; ra = '0; rl = '0; br = 1'b1; bb = 1'b0; bl = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", rr_busy, 0);
    chk("reset.bus_valid", rr_valid, 0);
    chk("reset.bus_addr", rr_addr, 0);
    chk("reset.bus_id", rr_id, 0);
    chk("reset.fp_busy", fp_busy, 0);

    // Single request, requester 0, len=3, four beats.
    @(posedge clk); #1;
    ra[31:0] = 32'h0000_1000; rl[7:0] = 8'd3; rw = '0; rv = 2'b01;
    rb = rr_ready_cnt; eb = rr_err_cnt;
    wait_valid(n);
    chk("single.latency", n, 2);
    chk("single.bus_addr", rr_addr, 32'h1000);
    chk("single.bus_len", rr_len, 3);
    chk("single.bus_id", rr_id, 0);
    chk("single.req_ready", rr_ready, 2'b01);
    beat(1'b0, 2'b00, e1);
    beat(1'b0, 2'b00, e1);
    beat(1'b0, 2'b00, e1);
    beat(1'b1, 2'b00, e1);
    end_beats();
    @(negedge clk);
    chk("single.req_done", rr_done, 2'b01);
    chk("single.ready_pulses", rr_ready_cnt - rb, 1);
    chk("single.err_pulses", rr_err_cnt - eb, 0);

    // Both requesters held: RR alternates, fixed priority keeps requester 0.
    pulse_reset();
    ib_rr = rr_ids.size(); ib_fp = fp_ids.size();
    mb_rr = q_mrr.size();  mb_fp = q_mfp.size();
    rl = '0; ra = {32'h0000_B000, 32'h0000_A000}; rw = 2'b10; rv = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_valid(n);
      beat(1'b1, 2'b11, e1);
      end_beats();
    end
    rv = 2'b10;
    wait_valid(n);
    beat(1'b1, 2'b00, e1);
    end_beats();
    @(negedge clk);
    chk("rr.grant_count", rr_ids.size() - ib_rr, 5);
    chk("fp.grant_count", fp_ids.size() - ib_fp, 5);
    for (int k = 0; k < 5; k++) begin
      if (ib_rr + k < rr_ids.size()) chk($sformatf("rr.grant%0d", k), rr_ids[ib_rr + k], exp_rr[k]);
      if (ib_fp + k < fp_ids.size()) chk($sformatf("fp.grant%0d", k), fp_ids[ib_fp + k], exp_fp[k]);
      if (mb_rr + k < q_mrr.size()) chk($sformatf("model.rr.grant%0d", k), q_mrr[mb_rr + k], exp_rr[k]);
      if (mb_fp + k < q_mfp.size()) chk($sformatf("model.fp.grant%0d", k), q_mfp[mb_fp + k], exp_fp[k]);
    end

    // Backpressure: address changes while the transaction waits in issue.
    @(posedge clk); #1;
    ra[31:0] = 32'h0000_2000; rl[7:0] = 8'd1; br = 1'b0; rv = 2'b01;
    wait_valid(n);
    chk("bp.ready_first", rr_ready, 0);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      ra[31:0] = $urandom;
      @(negedge clk);
      chk("bp.bus_addr", rr_addr, 32'h2000);
      chk("bp.req_ready", rr_ready, 0);
    end
    @(posedge clk); #1 br = 1'b1;
    @(negedge clk);
    chk("bp.req_ready_hs", rr_ready, 2'b01);
    chk("bp.bus_addr_hs", rr_addr, 32'h2000);
    beat(1'b0, 2'b00, e1);
    beat(1'b1, 2'b00, e1);
    end_beats();
    @(negedge clk);
    chk("bp.req_done", rr_done, 2'b01);

    // len=3 with last on beat 2: error on the early last, done still follows.
    @(posedge clk); #1;
    ra[31:0] = 32'h0000_3000; rl[7:0] = 8'd3; rv = 2'b01;
    wait_valid(n);
    beat(1'b0, 2'b00, e1);
    beat(1'b1, 2'b00, e2);
    chk("early_last.beat1_err", e1, 0);
    chk("early_last.beat2_err", e2, 1);
    end_beats();
    @(negedge clk);
    chk("early_last.req_done", rr_done, 2'b01);

    // len=1 with three beats, last on the third.
    @(posedge clk); #1;
    ra[31:0] = 32'h0000_3100; rl[7:0] = 8'd1; rv = 2'b01;
    wait_valid(n);
    beat(1'b0, 2'b00, e1);
    beat(1'b0, 2'b00, e2);
    beat(1'b1, 2'b00, e3);
    chk("overrun.beat1_err", e1, 0);
    chk("overrun.beat2_err", e2, 1);
    chk("overrun.beat3_err", e3, 1);
    end_beats();
    @(negedge clk);
    chk("overrun.req_done", rr_done, 2'b01);

    // Reset during a requester-1 burst: aborted, then requester 0 wins.
    @(posedge clk); #1;
    ra[63:32] = 32'h0000_4000; rl[15:8] = 8'd5; rv = 2'b10;
    wait_valid(n);
    chk("abort.bus_id", rr_id, 1);
    beat(1'b0, 2'b00, e1);
    beat(1'b0, 2'b00, e1);
    @(posedge clk); #1;
    bb = 1'b0; bl = 1'b0; rst = 1'b1;
    db = rr_done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort.busy", rr_busy, 0);
    chk("abort.bus_valid", rr_valid, 0);
    chk("abort.req_done", rr_done, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("abort.no_done", rr_done_cnt - db, 0);
    @(posedge clk); #1;
    rl[7:0] = 8'd0; rv = 2'b11;
    wait_valid(n);
    chk("abort.regrant_id", rr_id, 0);
    chk("abort.fp_regrant_id", fp_id, 0);
    beat(1'b1, 2'b00, e1);
    end_beats();
    @(negedge clk);
    chk("abort.final_done", rr_done, 2'b01);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
